// File: rtl/reg_pipe_chain.sv
// Parametrised register chain with valid/ready handshake, bubble collapsing,
// synchronous flush and registered occupancy count.
module reg_pipe_chain #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             flush,
  input  logic             s_valid,
  input  logic [WIDTH-1:0] s_data,
  output logic             s_ready,
  output logic             m_valid,
  output logic [WIDTH-1:0] m_data,
  input  logic             m_ready,
  output logic [CNT_W-1:0] occupancy,
  output logic             empty,
  output logic             full
);

  logic [DEPTH-1:0] valid_vec;
  logic [DEPTH-1:0] rdy;
  logic [DEPTH-1:0] nxt_valid;
  logic [WIDTH-1:0] data_vec [DEPTH];
  logic [CNT_W-1:0] nxt_cnt;

  // Ready ripples from the consumer back towards the producer; an empty
  // stage is always ready, which is what lets bubbles close under stall.
  always_comb begin
    rdy = '0;
    rdy[DEPTH-1] = ~valid_vec[DEPTH-1] | m_ready;
    for (int unsigned k = 1; k < DEPTH; k++) begin
      rdy[DEPTH-1-k] = ~valid_vec[DEPTH-1-k] | rdy[DEPTH-k];
    end
  end

  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    logic             valid_q;
    logic [WIDTH-1:0] data_q;
    logic             up_valid;
    logic [WIDTH-1:0] up_data;

    if (i == 0) begin : g_head
      assign up_valid = s_valid & ~flush;
      assign up_data  = s_data;
    end else begin : g_body
      assign up_valid = valid_vec[i-1];
      assign up_data  = data_vec[i-1];
    end

    assign nxt_valid[i] = flush ? 1'b0 : (rdy[i] ? up_valid : valid_q);

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        valid_q <= 1'b0;
        data_q  <= '0;
      end else begin
        valid_q <= nxt_valid[i];
        if (rdy[i] && up_valid && !flush) begin
          data_q <= up_data;
        end
      end
    end

    assign valid_vec[i] = valid_q;
    assign data_vec[i]  = data_q;
  end

  // Count the next-state valids so the registered count tracks valid_vec exactly.
  always_comb begin
    nxt_cnt = '0;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      nxt_cnt = nxt_cnt + CNT_W'(nxt_valid[k]);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      occupancy <= '0;
    end else begin
      occupancy <= nxt_cnt;
    end
  end

  assign s_ready = rdy[0] & ~flush;
  assign m_valid = valid_vec[DEPTH-1];
  assign m_data  = data_vec[DEPTH-1];
  assign empty   = (occupancy == '0);
  assign full    = (occupancy == CNT_W'(DEPTH));

endmodule

// File: tb/tb_reg_pipe_chain.sv
// Directed bench for reg_pipe_chain with a position-queue reference model
// checked every cycle plus hand-computed literal expectations.
module tb_reg_pipe_chain;
  localparam int WIDTH = 8;
  localparam int DEPTH = 4;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic             clk = 1'b0;
  logic             reset_n;
  logic             flush;
  logic             s_valid;
  logic [WIDTH-1:0] s_data;
  logic             s_ready;
  logic             m_valid;
  logic [WIDTH-1:0] m_data;
  logic             m_ready;
  logic [CNT_W-1:0] occupancy;
  logic             empty;
  logic             full;

  always #5 clk = ~clk;

  reg_pipe_chain #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset_n(reset_n), .flush(flush),
    .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
    .m_valid(m_valid), .m_data(m_data), .m_ready(m_ready),
    .occupancy(occupancy), .empty(empty), .full(full)
  );

  int vectors = 0;
  int miscompares = 0;

  // Model: words in flight, oldest first, each with the stage index it occupies.
  int q_data[$];
  int q_pos[$];
  int out_log[$];
  int acc_cnt;
  bit dut_accepted;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_compare();
    int  cnt;
    bit  exp_mv;
    bit  exp_sr;
    cnt    = q_pos.size();
    exp_mv = (cnt > 0) && (q_pos[0] == DEPTH - 1);
    exp_sr = !flush && ((cnt < DEPTH) || m_ready);
    chk("m_valid", 32'(m_valid), 32'(exp_mv));
    if (exp_mv) chk("m_data", 32'(m_data), 32'(q_data[0]));
    chk("occupancy", 32'(occupancy), 32'(cnt));
    chk("empty", 32'(empty), 32'(cnt == 0));
    chk("full", 32'(full), 32'(cnt == DEPTH));
    chk("s_ready", 32'(s_ready), 32'(exp_sr));
  endtask

  task automatic model_edge();
    bit acc;
    bit pop;
    int lim;
    acc = s_valid && !flush && ((q_pos.size() < DEPTH) || m_ready);
    pop = (q_pos.size() > 0) && (q_pos[0] == DEPTH - 1) && m_ready;
    if (flush) begin
      q_data.delete();
      q_pos.delete();
    end else begin
      if (pop) begin
        void'(q_data.pop_front());
        void'(q_pos.pop_front());
      end
      for (int j = 0; j < q_pos.size(); j++) begin
        lim = (j == 0) ? DEPTH - 1 : q_pos[j-1] - 1;
        if (q_pos[j] < lim) q_pos[j] = q_pos[j] + 1;
      end
      if (acc) begin
        q_data.push_back(int'(s_data));
        q_pos.push_back(0);
      end
    end
  endtask

  task automatic step(input logic sv, input logic [WIDTH-1:0] sd, input logic mr, input logic fl);
    @(negedge clk);
    s_valid = sv;
    s_data  = sd;
    m_ready = mr;
    flush   = fl;
    #1;
    model_compare();
    dut_accepted = s_valid && s_ready;
    if (dut_accepted) acc_cnt++;
    if (m_valid && m_ready) out_log.push_back(int'(m_data));
    model_edge();
  endtask

  task automatic idle(input int n, input logic mr);
    for (int i = 0; i < n; i++) step(1'b0, '0, mr, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int wi;
    reset_n = 1'b0; flush = 1'b0; s_valid = 1'b0; s_data = '0; m_ready = 1'b0;
    acc_cnt = 0; dut_accepted = 1'b0;
    #3;
    chk("rst_m_valid", 32'(m_valid), 32'd0);
    chk("rst_m_data", 32'(m_data), 32'd0);
    chk("rst_occupancy", 32'(occupancy), 32'd0);
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_s_ready", 32'(s_ready), 32'd1);
    @(negedge clk);
    reset_n = 1'b1;

    // Streaming 0x01..0x10 with the consumer always ready.
    out_log.delete();
    for (int i = 1; i <= 16; i++) begin
      step(1'b1, WIDTH'(i), 1'b1, 1'b0);
      if (i == 5) begin
        chk("stream_first_valid", 32'(m_valid), 32'd1);
        chk("stream_first_data", 32'(m_data), 32'h01);
      end
      if (i >= 5) chk("stream_occ", 32'(occupancy), 32'd4);
    end
    idle(6, 1'b1);
    chk("stream_count", 32'(out_log.size()), 32'd16);
    for (int i = 0; i < out_log.size() && i < 16; i++)
      chk("stream_order", 32'(out_log[i]), 32'(i + 1));

    // Back-pressure: producer holds each word until accepted.
    out_log.delete();
    acc_cnt = 0;
    wi = 0;
    for (int c = 0; c < 6; c++) begin
      step(1'b1, WIDTH'(8'hA0 + wi), 1'b0, 1'b0);
      if (dut_accepted) wi++;
    end
    chk("bp_accepted", 32'(acc_cnt), 32'd4);
    chk("bp_full", 32'(full), 32'd1);
    chk("bp_s_ready", 32'(s_ready), 32'd0);
    for (int c = 0; c < 20 && wi < 6; c++) begin
      step(1'b1, WIDTH'(8'hA0 + wi), 1'b1, 1'b0);
      if (dut_accepted) wi++;
    end
    chk("bp_all_accepted", 32'(wi), 32'd6);
    idle(8, 1'b1);
    chk("bp_count", 32'(out_log.size()), 32'd6);
    for (int i = 0; i < out_log.size() && i < 6; i++)
      chk("bp_order", 32'(out_log[i]), 32'(8'hA0 + i));

    // Bubble collapse under stall.
    step(1'b1, 8'h11, 1'b0, 1'b0);
    idle(2, 1'b0);
    step(1'b1, 8'h22, 1'b0, 1'b0);
    idle(3, 1'b0);
    chk("bubble_occ", 32'(occupancy), 32'd2);
    step(1'b0, '0, 1'b1, 1'b0);
    chk("bubble_first", 32'(m_data), 32'h11);
    step(1'b0, '0, 1'b1, 1'b0);
    chk("bubble_second_valid", 32'(m_valid), 32'd1);
    chk("bubble_second", 32'(m_data), 32'h22);
    idle(3, 1'b1);

    // Full chain with simultaneous push and pop.
    for (int k = 0; k < 4; k++) step(1'b1, WIDTH'(8'hB0 + k), 1'b0, 1'b0);
    for (int k = 0; k < 4; k++) begin
      step(1'b1, WIDTH'(8'hB4 + k), 1'b1, 1'b0);
      chk("pp_occ", 32'(occupancy), 32'd4);
      chk("pp_full", 32'(full), 32'd1);
      chk("pp_s_ready", 32'(s_ready), 32'd1);
    end
    idle(6, 1'b1);

    // Flush with three words resident.
    for (int k = 0; k < 3; k++) step(1'b1, WIDTH'(8'hC0 + k), 1'b0, 1'b0);
    step(1'b1, 8'hC3, 1'b0, 1'b1);
    chk("flush_s_ready", 32'(s_ready), 32'd0);
    chk("flush_occ_before", 32'(occupancy), 32'd3);
    step(1'b0, '0, 1'b0, 1'b0);
    chk("flush_occ_after", 32'(occupancy), 32'd0);
    chk("flush_m_valid", 32'(m_valid), 32'd0);
    step(1'b1, 8'h55, 1'b1, 1'b0);
    idle(4, 1'b1);
    chk("flush_next_valid", 32'(m_valid), 32'd1);
    chk("flush_next_data", 32'(m_data), 32'h55);
    idle(2, 1'b1);

    // Asynchronous reset with the chain full.
    for (int k = 0; k < 4; k++) step(1'b1, WIDTH'(8'hD0 + k), 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0);
    chk("pre_reset_full", 32'(full), 32'd1);
    @(negedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    chk("async_m_valid", 32'(m_valid), 32'd0);
    chk("async_occ", 32'(occupancy), 32'd0);
    chk("async_full", 32'(full), 32'd0);
    chk("async_empty", 32'(empty), 32'd1);
    chk("async_s_ready", 32'(s_ready), 32'd1);
    q_data.delete();
    q_pos.delete();
    @(negedge clk);
    reset_n = 1'b1;
    step(1'b1, 8'h77, 1'b1, 1'b0);
    idle(5, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
